// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx receive path.
package uart_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200
  localparam int MAX_DATA_BITS        = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL selects the idle level the chain holds during reset.
module rx_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  // metastability filter: d_i -> meta -> q_o
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta <= RST_VAL;
      q_o  <= RST_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised asynchronous serial receiver, LSB-first, 1 or 2 stop bits.
// Optional parity check is compiled in with macro UART_RX_PARITY_EN;
// without it the frame is start + DATA_BITS + stop and parity_err_o is 0.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(MAX_DATA_BITS);
  localparam logic [CW-1:0] HALF_T    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_T    = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_chk
    $error("uart_rx_param: illegal parameter set");
  end

  logic                 rx_s;
  rx_state_e            state, state_n;
  logic [CW-1:0]        cnt;
  logic                 tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 fe_q;
  logic                 load, ovr;

  rx_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  // START waits half a bit to land mid start bit; all other states a full bit
  assign tick   = (cnt == ((state == START) ? HALF_T : FULL_T));
  assign busy_o = (state != IDLE);

  // state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  // bit timer and bit counter, both restart on every state entry
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (state_n != state) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick && (state == DATA || state == STOP)) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // shift register (MSB-in so the first line bit ends at bit 0) and stop check
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg <= '0;
      fe_q  <= 1'b0;
    end else begin
      if (state == IDLE)                      fe_q  <= 1'b0;
      if (tick && state == DATA)              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (tick && state == STOP && !rx_s)     fe_q  <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;

  // parity error: XOR of data and parity bit must equal PARITY_ODD
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                        par_q <= 1'b0;
    else if (tick && state == PARITY)   par_q <= (^shreg) ^ rx_s ^ 1'(PARITY_ODD);
  end
`endif

  // next state plus DONE-cycle load / overrun decision
  always_comb begin
    state_n = state;
    load    = 1'b0;
    ovr     = 1'b0;
    case (state)
      IDLE:   if (!rx_s) state_n = START;
      START:  if (tick)  state_n = rx_s ? IDLE : DATA;
      DATA:   if (tick && bit_cnt == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
                state_n = PARITY;
`else
                state_n = STOP;
`endif
              end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) state_n = STOP;
`endif
      STOP:   if (tick && bit_cnt == LAST_STOP) state_n = DONE;
      DONE: begin
        load    = !valid_o || ready_i;
        ovr     = valid_o && !ready_i;
        // a low stop bit may be a break; hold off until the line recovers
        state_n = fe_q ? BREAK : IDLE;
      end
      BREAK:  if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // output word register with valid/ready handshake
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_o      <= '0;
      frame_err_o <= 1'b0;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      overrun_o <= ovr;
      if (load) begin
        data_o      <= shreg;
        frame_err_o <= fe_q;
        valid_o     <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o     <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // parity flag travels with the word
  always_ff @(posedge clk_i) begin
    if (!rst_ni)   parity_err_o <= 1'b0;
    else if (load) parity_err_o <= par_q;
  end
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and a 5-data/2-stop instance.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // 8-bit, 1 stop instance
  logic       rst8_n, rx8, rdy8;
  logic [7:0] d8;
  logic       v8, fe8, pe8, ov8, bsy8;
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u8 (
    .clk_i(clk), .rst_ni(rst8_n), .rx_i(rx8), .data_o(d8), .valid_o(v8), .ready_i(rdy8),
    .frame_err_o(fe8), .parity_err_o(pe8), .overrun_o(ov8), .busy_o(bsy8));

  // 5-bit, 2 stop instance
  logic       rst5_n, rx5, rdy5;
  logic [4:0] d5;
  logic       v5, fe5, pe5, ov5, bsy5;
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) u5 (
    .clk_i(clk), .rst_ni(rst5_n), .rx_i(rx5), .data_o(d5), .valid_o(v5), .ready_i(rdy5),
    .frame_err_o(fe5), .parity_err_o(pe5), .overrun_o(ov5), .busy_o(bsy5));

  // handshake / overrun / valid-rise monitors, sampled on the falling edge
  int         hs8 = 0, ovc8 = 0, rise8 = -1, e8 = 0;
  logic [7:0] hd8 = '0;
  logic       hfe8 = 1'b0, hpe8 = 1'b0, v8_q = 1'b0;
  always @(negedge clk) begin
    v8_q <= v8;
    if (v8 && !v8_q) rise8 <= cyc;
    if (v8 && rdy8) begin hs8 <= hs8 + 1; hd8 <= d8; hfe8 <= fe8; hpe8 <= pe8; end
    if (ov8) ovc8 <= ovc8 + 1;
  end

  int         hs5 = 0, rise5 = -1, e5 = 0;
  logic [4:0] hd5 = '0;
  logic       hfe5 = 1'b0, v5_q = 1'b0;
  always @(negedge clk) begin
    v5_q <= v5;
    if (v5 && !v5_q) rise5 <= cyc;
    if (v5 && rdy5) begin hs5 <= hs5 + 1; hd5 <= d5; hfe5 <= fe5; end
  end

  // frame drivers; called and returning on a falling edge, line left at stop level
  task automatic send8(input logic [7:0] d, input logic p, input logic stop);
    rx8 = 1'b0; e8 = cyc + 1; repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx8 = d[i]; repeat (CPB) @(negedge clk); end
    if (PB == 1) begin rx8 = p; repeat (CPB) @(negedge clk); end
    rx8 = stop; repeat (CPB) @(negedge clk);
  endtask

  task automatic send5(input logic [4:0] d, input logic p);
    rx5 = 1'b0; e5 = cyc + 1; repeat (CPB) @(negedge clk);
    for (int i = 0; i < 5; i++) begin rx5 = d[i]; repeat (CPB) @(negedge clk); end
    if (PB == 1) begin rx5 = p; repeat (CPB) @(negedge clk); end
    rx5 = 1'b1; repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst8_n = 1'b0; rst5_n = 1'b0; rx8 = 1'b1; rx5 = 1'b1; rdy8 = 1'b1; rdy5 = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (d8 !== 8'h00)  begin n_bad++; $display("FAIL reset_data: got %h want 00", d8); end
    n_cmp++; if (v8 !== 1'b0)   begin n_bad++; $display("FAIL reset_valid: got %b want 0", v8); end
    n_cmp++; if (fe8 !== 1'b0)  begin n_bad++; $display("FAIL reset_fe: got %b want 0", fe8); end
    n_cmp++; if (pe8 !== 1'b0)  begin n_bad++; $display("FAIL reset_pe: got %b want 0", pe8); end
    n_cmp++; if (ov8 !== 1'b0)  begin n_bad++; $display("FAIL reset_ovr: got %b want 0", ov8); end
    n_cmp++; if (bsy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bsy8); end
    rst8_n = 1'b1; rst5_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // 0xA5 8N1: valid rises E + 2 + CPB/2 + (8+PB+1)*CPB + 1 (= E+155 without parity)
  task automatic test_basic();
    int h0, exp_rise;
    h0 = hs8;
    send8(8'hA5, 1'b0, 1'b1);
    @(negedge clk);
    exp_rise = e8 + 2 + CPB / 2 + (8 + PB + 1) * CPB + 1;
    n_cmp++; if (hs8 - h0 !== 1)  begin n_bad++; $display("FAIL basic_pulses: got %0d want 1", hs8 - h0); end
    n_cmp++; if (hd8 !== 8'hA5)   begin n_bad++; $display("FAIL basic_data: got %h want a5", hd8); end
    n_cmp++; if (hfe8 !== 1'b0)   begin n_bad++; $display("FAIL basic_fe: got %b want 0", hfe8); end
    n_cmp++; if (hpe8 !== 1'b0)   begin n_bad++; $display("FAIL basic_pe: got %b want 0", hpe8); end
    n_cmp++; if (rise8 !== exp_rise) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", rise8, exp_rise); end
    n_cmp++; if (v8 !== 1'b0)     begin n_bad++; $display("FAIL basic_valid_clr: got %b want 0", v8); end
  endtask

  task automatic test_glitch();
    int h0;
    h0 = hs8;
    rx8 = 1'b0; repeat (4) @(negedge clk);
    n_cmp++; if (bsy8 !== 1'b1) begin n_bad++; $display("FAIL glitch_busy: got %b want 1", bsy8); end
    rx8 = 1'b1; repeat (2 * CPB) @(negedge clk);
    n_cmp++; if (bsy8 !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: got %b want 0", bsy8); end
    n_cmp++; if (v8 !== 1'b0)   begin n_bad++; $display("FAIL glitch_valid: got %b want 0", v8); end
    n_cmp++; if (hs8 !== h0)    begin n_bad++; $display("FAIL glitch_words: got %0d want %0d", hs8, h0); end
  endtask

  task automatic test_break();
    int h0;
    h0 = hs8;
    send8(8'h3C, 1'b0, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    n_cmp++; if (hs8 - h0 !== 1) begin n_bad++; $display("FAIL break_words: got %0d want 1", hs8 - h0); end
    n_cmp++; if (hd8 !== 8'h3C)  begin n_bad++; $display("FAIL break_data: got %h want 3c", hd8); end
    n_cmp++; if (hfe8 !== 1'b1)  begin n_bad++; $display("FAIL break_fe: got %b want 1", hfe8); end
    n_cmp++; if (bsy8 !== 1'b1)  begin n_bad++; $display("FAIL break_busy: got %b want 1", bsy8); end
    rx8 = 1'b1; repeat (CPB) @(negedge clk);
    n_cmp++; if (bsy8 !== 1'b0)  begin n_bad++; $display("FAIL break_release: got %b want 0", bsy8); end
    send8(8'h55, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++; if (hs8 - h0 !== 2) begin n_bad++; $display("FAIL break_next_words: got %0d want 2", hs8 - h0); end
    n_cmp++; if (hd8 !== 8'h55)  begin n_bad++; $display("FAIL break_next_data: got %h want 55", hd8); end
    n_cmp++; if (hfe8 !== 1'b0)  begin n_bad++; $display("FAIL break_next_fe: got %b want 0", hfe8); end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    send8(8'h01, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (hd8 !== 8'h01) begin n_bad++; $display("FAIL par_ok_data: got %h want 01", hd8); end
    n_cmp++; if (hpe8 !== 1'b0) begin n_bad++; $display("FAIL par_ok_pe: got %b want 0", hpe8); end
    send8(8'h01, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++; if (hpe8 !== 1'b1) begin n_bad++; $display("FAIL par_bad_pe: got %b want 1", hpe8); end
    n_cmp++; if (hfe8 !== 1'b0) begin n_bad++; $display("FAIL par_bad_fe: got %b want 0", hfe8); end
`else
    send8(8'h01, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++; if (hd8 !== 8'h01) begin n_bad++; $display("FAIL nopar_data: got %h want 01", hd8); end
    n_cmp++; if (hpe8 !== 1'b0) begin n_bad++; $display("FAIL nopar_pe: got %b want 0", hpe8); end
`endif
  endtask

  task automatic test_back_to_back();
    int h0, o0;
    @(posedge clk); #1 rdy8 = 1'b0; @(negedge clk);
    h0 = hs8; o0 = ovc8;
    send8(8'h11, 1'b0, 1'b1);
    send8(8'h22, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++; if (v8 !== 1'b1)       begin n_bad++; $display("FAIL ovr_valid: got %b want 1", v8); end
    n_cmp++; if (d8 !== 8'h11)      begin n_bad++; $display("FAIL ovr_hold: got %h want 11", d8); end
    n_cmp++; if (ovc8 - o0 !== 1)   begin n_bad++; $display("FAIL ovr_pulses: got %0d want 1", ovc8 - o0); end
    n_cmp++; if (hs8 !== h0)        begin n_bad++; $display("FAIL ovr_no_accept: got %0d want %0d", hs8, h0); end
    @(posedge clk); #1 rdy8 = 1'b1; @(negedge clk);
    @(negedge clk);
    n_cmp++; if (v8 !== 1'b0)       begin n_bad++; $display("FAIL ovr_valid_clr: got %b want 0", v8); end
    n_cmp++; if (hs8 - h0 !== 1)    begin n_bad++; $display("FAIL ovr_accept: got %0d want 1", hs8 - h0); end
    n_cmp++; if (hd8 !== 8'h11)     begin n_bad++; $display("FAIL ovr_word: got %h want 11", hd8); end
  endtask

  // 5 data, 2 stop: valid rises E + 2 + CPB/2 + (5+PB+2)*CPB + 1
  task automatic test_reset_midframe();
    int h0, exp_rise;
    h0 = hs5;
    send5(5'h1F, 1'b1);
    @(negedge clk);
    exp_rise = e5 + 2 + CPB / 2 + (5 + PB + 2) * CPB + 1;
    n_cmp++; if (hs5 - h0 !== 1)  begin n_bad++; $display("FAIL d5_words: got %0d want 1", hs5 - h0); end
    n_cmp++; if (hd5 !== 5'h1F)   begin n_bad++; $display("FAIL d5_data: got %h want 1f", hd5); end
    n_cmp++; if (hfe5 !== 1'b0)   begin n_bad++; $display("FAIL d5_fe: got %b want 0", hfe5); end
    n_cmp++; if (rise5 !== exp_rise) begin n_bad++; $display("FAIL d5_latency: got %0d want %0d", rise5, exp_rise); end
    // start of 0x0A: start bit, bit0=0, half of bit1=1, then reset
    rx5 = 1'b0; repeat (2 * CPB) @(negedge clk);
    rx5 = 1'b1; repeat (CPB / 2) @(negedge clk);
    n_cmp++; if (bsy5 !== 1'b1)   begin n_bad++; $display("FAIL d5_midframe_busy: got %b want 1", bsy5); end
    rst5_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (d5 !== 5'h00)    begin n_bad++; $display("FAIL d5_rst_data: got %h want 00", d5); end
    n_cmp++; if (v5 !== 1'b0)     begin n_bad++; $display("FAIL d5_rst_valid: got %b want 0", v5); end
    n_cmp++; if (fe5 !== 1'b0)    begin n_bad++; $display("FAIL d5_rst_fe: got %b want 0", fe5); end
    n_cmp++; if (pe5 !== 1'b0)    begin n_bad++; $display("FAIL d5_rst_pe: got %b want 0", pe5); end
    n_cmp++; if (ov5 !== 1'b0)    begin n_bad++; $display("FAIL d5_rst_ovr: got %b want 0", ov5); end
    n_cmp++; if (bsy5 !== 1'b0)   begin n_bad++; $display("FAIL d5_rst_busy: got %b want 0", bsy5); end
    rst5_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (hs5 - h0 !== 1)  begin n_bad++; $display("FAIL d5_abandon: got %0d want 1", hs5 - h0); end
    send5(5'h0A, 1'b0);
    @(negedge clk);
    n_cmp++; if (hs5 - h0 !== 2)  begin n_bad++; $display("FAIL d5_next_words: got %0d want 2", hs5 - h0); end
    n_cmp++; if (hd5 !== 5'h0A)   begin n_bad++; $display("FAIL d5_next_data: got %h want 0a", hd5); end
    n_cmp++; if (hfe5 !== 1'b0)   begin n_bad++; $display("FAIL d5_next_fe: got %b want 0", hfe5); end
  endtask

  initial begin
    rst8_n = 1'b0; rst5_n = 1'b0; rx8 = 1'b1; rx5 = 1'b1; rdy8 = 1'b1; rdy5 = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised RS-232 asynchronous serial receiver: synchronises the raw line, qualifies the start bit at mid-bit, and shifts in a configurable number of data bits LSB-first. Optionally checks parity, then checks 1 or 2 stop bits. It presents the received word with error flags on a valid/ready output port. It is the receive front end between the board RX pin and the parallel word consumer (register file / PIPO stage).

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Must be ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, 5..9.
- `STOP_BITS`, default 1: stop bits checked, 1 or 2.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Used only with `UART_RX_PARITY_EN`.
- `clk_i`  in  1  single system clock; all logic on rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `rx_i`  in  1  asynchronous serial line; idle high.
- `data_o`  out  DATA_BITS  received word; bit 0 = first bit on the line.
- `valid_o`  out  1  `data_o` and the error flags hold a word.
- `ready_i`  in  1  consumer accepts the word when `valid_o && ready_i`.
- `frame_err_o`  out  1  a stop bit of the word on `data_o` sampled low; qualified by `valid_o`.
- `parity_err_o`  out  1  parity mismatch on the word on `data_o`; qualified by `valid_o`; constant 0 without the macro.
- `overrun_o`  out  1  one-cycle pulse when a frame completes while `valid_o` is still high.
- `busy_o`  out  1  FSM not in IDLE.

## Operation
- `rx_i` passes through a 2-FF synchronizer (reset value 1). The FSM sees `rx_s`.
- Bit-timer counter width is `$clog2(CLKS_PER_BIT)`. It reloads to 0 on every state entry and produces `tick` when it reaches the terminal value.
- States and transitions:
  - IDLE -> START when `rx_s`=0.
  - START: `tick` at count `CLKS_PER_BIT/2 - 1` (integer division), which is mid start bit.
    - `rx_s`=1 at that point -> IDLE (false start, nothing reported).
    - `rx_s`=0 -> DATA.
  - DATA: samples `rx_s` every `CLKS_PER_BIT` cycles into a right-shift register, MSB-in. Bit counter 0..DATA_BITS-1. After the last bit -> PARITY if enabled, else STOP.
  - PARITY: one sample. Error if XOR(data bits, sample) ≠ `PARITY_ODD`.
  - STOP: `STOP_BITS` samples. Any low sample sets frame error. After the last sample -> DONE.
  - DONE: one cycle. Loads the output register, then:
    - frame error -> BREAK;
    - otherwise -> IDLE.
  - BREAK: waits for `rx_s`=1, then -> IDLE. A low line never retriggers a frame.
- Output register behaviour:
  - In DONE with `valid_o`=0 (or `valid_o && ready_i` in the same cycle): load `data_o` and both error flags, set `valid_o`.
  - In DONE with `valid_o`=1 and `ready_i`=0: keep the old word, drop the new one, pulse `overrun_o`.
  - `valid_o` clears on `valid_o && ready_i` unless a load happens in the same cycle.
  - `data_o` and the flags are stable while `valid_o`=1 and `ready_i`=0.
- Reset values:
  - `data_o`=0, `valid_o`=0, all error flags 0, `overrun_o`=0, `busy_o`=0.
  - FSM in IDLE, synchronizer at 1.
  - Reset mid-frame abandons the frame and reports nothing.

## Timing
- Let E be the first `clk_i` edge at which `rx_i`=0 is registered. `rx_s` goes low 2 cycles later.
- The mid start sample falls `CLKS_PER_BIT/2` cycles after START entry.
- Data bit k is sampled at mid-start + (k+1)·`CLKS_PER_BIT`.
- DONE occurs one cycle after the final stop sample. `valid_o` rises one cycle after DONE.
- Earliest next start detection is the cycle after DONE (IDLE entry), which is half a bit before the nominal end of the stop bit.
- The receiver tolerates roughly ±4 % baud mismatch at 10-bit frames.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined: PARITY state present and one extra bit per frame expected; `parity_err_o` is live.
- Undefined: no PARITY state, frame = start + DATA_BITS + stop; `parity_err_o` tied to 0.

## Structure
- Package `uart_rx_pkg` holds:
  - FSM state typedef: IDLE, START, DATA, PARITY, STOP, DONE, BREAK;
  - shared localparams: `DEFAULT_CLKS_PER_BIT`, `MAX_DATA_BITS`=9.
- Sub-module `rx_sync2`: 2-FF synchronizer with parametrised reset value, reused by other async inputs.
- Top module holds the FSM, bit timer, bit counter, shift register and output register.

## Test plan
- CLKS_PER_BIT=16, 8N1, send 0xA5, `ready_i`=1 -> `data_o`=0xA5 and `valid_o` pulse for one cycle; check the expected cycle from E, no error flags.
- Line low for 4 cycles then high (glitch) -> FSM returns to IDLE, `valid_o` stays 0.
- Send 0x3C with the stop bit forced low, then hold the line low for 3 bit times -> `data_o`=0x3C and `frame_err_o`=1. No new frame until the line goes high, then 0x55 is received correctly.
- With `UART_RX_PARITY_EN`, even parity:
  - send 0x01 with parity bit 1 -> `parity_err_o`=0;
  - send 0x01 with parity bit 0 -> `parity_err_o`=1.
- `ready_i`=0, send 0x11 then 0x22 back-to-back -> `data_o` holds 0x11 and `overrun_o` pulses once. Raising `ready_i` clears `valid_o`.
- DATA_BITS=5, STOP_BITS=2, send 0x1F, then assert reset mid-frame on the next frame -> 0x1F delivered; after reset all outputs are 0 and the next frame 0x0A is received correctly.
